// File: rtl/oper_latch_if.sv
// Operator-key bundle between keypad decoder, operator latch and ALU sequencer.
// The slave side is the latch; the master side drives keys and consumes operators.
interface oper_latch_if #(
  parameter int KEY_W   = 5,
  parameter int COUNT_W = 4
);
  logic [KEY_W-1:0]   key;
  logic               press;
  logic               hold;
  logic               clear;
  logic               op_ready;
  logic [KEY_W-1:0]   op_code;
  logic               op_valid;
  logic               rejected;
  logic [COUNT_W-1:0] op_count;

  modport master (
    output key, press, hold, clear, op_ready,
    input  op_code, op_valid, rejected, op_count
  );

  modport slave (
    input  key, press, hold, clear, op_ready,
    output op_code, op_valid, rejected, op_count
  );
endinterface

// File: rtl/oper_latch_hs.sv
// Operator-key register: captures an operator on a rising press edge and offers it
// to the ALU sequencer over valid/ready, with hold, clear, overwrite policy and a counter.
module oper_latch_hs #(
  parameter int               KEY_W      = 5,
  parameter int               OP_MIN     = 10,
  parameter int               OP_MAX     = 13,
  parameter logic [KEY_W-1:0] EMPTY_CODE = '1,
  parameter bit               OVERWRITE  = 1'b1,
  parameter int               COUNT_W    = 4
) (
  input  logic        clock,
  input  logic        reset,
  oper_latch_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PENDING,
    ST_CONSUMED
  } state_t;

  localparam logic [KEY_W-1:0]   OP_LO     = KEY_W'(OP_MIN);
  localparam logic [KEY_W-1:0]   OP_HI     = KEY_W'(OP_MAX);
  localparam logic [COUNT_W-1:0] COUNT_TOP = '1;

  state_t             state_reg;
  logic               press_q;
  logic [KEY_W-1:0]   op_code_reg;
  logic               op_valid_reg;
  logic               rejected_reg;
  logic [COUNT_W-1:0] op_count_reg;

  logic               press_edge;
  logic               key_in_range;
  logic               accept;
  logic [COUNT_W-1:0] count_inc;

  assign press_edge   = bus.press & ~press_q;
  assign key_in_range = (bus.key >= OP_LO) && (bus.key <= OP_HI);
  assign accept       = press_edge & ~bus.hold & key_in_range;
  assign count_inc    = (op_count_reg == COUNT_TOP) ? op_count_reg : op_count_reg + 1'b1;

  always_ff @(posedge clock) begin
    // press history tracks the pin even through reset/clear, so a held key never re-fires
    press_q <= bus.press;
    if (reset) begin
      state_reg    <= ST_EMPTY;
      op_code_reg  <= EMPTY_CODE;
      op_valid_reg <= 1'b0;
      rejected_reg <= 1'b0;
      op_count_reg <= '0;
    end else if (bus.clear) begin
      state_reg    <= ST_EMPTY;
      op_code_reg  <= EMPTY_CODE;
      op_valid_reg <= 1'b0;
      rejected_reg <= 1'b0;
      op_count_reg <= '0;
    end else begin
      rejected_reg <= 1'b0;
      case (state_reg)
        ST_EMPTY, ST_CONSUMED: begin
          if (accept) begin
            state_reg    <= ST_PENDING;
            op_code_reg  <= bus.key;
            op_valid_reg <= 1'b1;
            op_count_reg <= count_inc;
          end
        end
        ST_PENDING: begin
          if (accept && (bus.op_ready || OVERWRITE)) begin
            // consumed-and-reloaded in one cycle never counts as a rejection
            op_code_reg  <= bus.key;
            op_count_reg <= count_inc;
          end else if (accept) begin
            rejected_reg <= 1'b1;
          end else if (bus.op_ready) begin
            state_reg    <= ST_CONSUMED;
            op_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg    <= ST_EMPTY;
          op_code_reg  <= EMPTY_CODE;
          op_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_code  = op_code_reg;
  assign bus.op_valid = op_valid_reg;
  assign bus.rejected = rejected_reg;
  assign bus.op_count = op_count_reg;

endmodule

// File: tb/tb_oper_latch_hs.sv
// Bench for oper_latch_hs: three instances (overwrite, no-overwrite, 2-bit counter)
// share one stimulus stream; a vector table feeds a scoreboard queue checked after each edge.
module tb_oper_latch_hs;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  oper_latch_if #(.KEY_W(5), .COUNT_W(4)) if_a ();
  oper_latch_if #(.KEY_W(5), .COUNT_W(4)) if_b ();
  oper_latch_if #(.KEY_W(5), .COUNT_W(2)) if_c ();

  assign if_b.key      = if_a.key;
  assign if_b.press    = if_a.press;
  assign if_b.hold     = if_a.hold;
  assign if_b.clear    = if_a.clear;
  assign if_b.op_ready = if_a.op_ready;
  assign if_c.key      = if_a.key;
  assign if_c.press    = if_a.press;
  assign if_c.hold     = if_a.hold;
  assign if_c.clear    = if_a.clear;
  assign if_c.op_ready = if_a.op_ready;

  oper_latch_hs #(.OVERWRITE(1'b1), .COUNT_W(4)) dut_a (.clock(clock), .reset(reset), .bus(if_a));
  oper_latch_hs #(.OVERWRITE(1'b0), .COUNT_W(4)) dut_b (.clock(clock), .reset(reset), .bus(if_b));
  oper_latch_hs #(.OVERWRITE(1'b1), .COUNT_W(2)) dut_c (.clock(clock), .reset(reset), .bus(if_c));

  typedef struct {
    logic       rst, clr, hold, press, rdy;
    logic [4:0] key;
    logic [4:0] a_code; logic a_valid, a_rej; logic [3:0] a_cnt;
    logic [4:0] b_code; logic b_valid, b_rej; logic [3:0] b_cnt;
    logic [1:0] c_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic add(input logic rst, clr, hold, press, rdy, input logic [4:0] key,
                     input logic [4:0] ac, input logic av, ar, input logic [3:0] an,
                     input logic [4:0] bc, input logic bv, br, input logic [3:0] bn,
                     input logic [1:0] cn);
    vec_t v;
    v.rst = rst; v.clr = clr; v.hold = hold; v.press = press; v.rdy = rdy; v.key = key;
    v.a_code = ac; v.a_valid = av; v.a_rej = ar; v.a_cnt = an;
    v.b_code = bc; v.b_valid = bv; v.b_rej = br; v.b_cnt = bn;
    v.c_cnt = cn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
  endtask

  task automatic drive(input logic rst, clr, hold, press, rdy, input logic [4:0] key);
    reset         = rst;
    if_a.clear    = clr;
    if_a.hold     = hold;
    if_a.press    = press;
    if_a.op_ready = rdy;
    if_a.key      = key;
  endtask

  initial begin
    vec_t v;
    vec_t e;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

    //   rst clr hld prs rdy key | A: code v r cnt | B: code v r cnt | C cnt
    add(1, 0, 0, 0, 0, 0,   31, 0, 0, 0,   31, 0, 0, 0,   0); // reset state
    add(1, 0, 0, 0, 0, 0,   31, 0, 0, 0,   31, 0, 0, 0,   0);
    add(0, 0, 0, 0, 0, 11,  31, 0, 0, 0,   31, 0, 0, 0,   0);
    add(0, 0, 0, 1, 0, 11,  11, 1, 0, 1,   11, 1, 0, 1,   1); // edge captures 11
    add(0, 0, 0, 1, 0, 11,  11, 1, 0, 1,   11, 1, 0, 1,   1); // level held: no re-trigger
    add(0, 0, 0, 1, 0, 11,  11, 1, 0, 1,   11, 1, 0, 1,   1);
    add(0, 0, 0, 1, 0, 11,  11, 1, 0, 1,   11, 1, 0, 1,   1);
    add(0, 0, 0, 1, 0, 11,  11, 1, 0, 1,   11, 1, 0, 1,   1);
    add(0, 0, 0, 0, 1, 11,  11, 0, 0, 1,   11, 0, 0, 1,   1); // consumed, code kept
    add(0, 0, 0, 1, 0, 5,   11, 0, 0, 1,   11, 0, 0, 1,   1); // out of range
    add(0, 0, 0, 0, 0, 5,   11, 0, 0, 1,   11, 0, 0, 1,   1);
    add(0, 0, 0, 1, 0, 10,  10, 1, 0, 2,   10, 1, 0, 2,   2);
    add(0, 0, 0, 0, 0, 10,  10, 1, 0, 2,   10, 1, 0, 2,   2);
    add(0, 0, 0, 1, 0, 12,  12, 1, 0, 3,   10, 1, 1, 2,   3); // overwrite vs reject
    add(0, 0, 0, 0, 0, 12,  12, 1, 0, 3,   10, 1, 0, 2,   3); // reject is one cycle
    add(0, 0, 0, 0, 1, 0,   12, 0, 0, 3,   10, 0, 0, 2,   3);
    add(0, 0, 0, 1, 0, 10,  10, 1, 0, 4,   10, 1, 0, 3,   3); // C saturates
    add(0, 0, 0, 0, 0, 10,  10, 1, 0, 4,   10, 1, 0, 3,   3);
    add(0, 0, 0, 1, 1, 13,  13, 1, 0, 5,   13, 1, 0, 4,   3); // consume + load same cycle
    add(0, 0, 0, 0, 0, 13,  13, 1, 0, 5,   13, 1, 0, 4,   3);
    add(0, 0, 1, 1, 0, 12,  13, 1, 0, 5,   13, 1, 0, 4,   3); // hold blocks, no reject
    add(0, 0, 1, 0, 1, 12,  13, 0, 0, 5,   13, 0, 0, 4,   3); // ready works under hold
    add(0, 1, 0, 1, 0, 11,  31, 0, 0, 0,   31, 0, 0, 0,   0); // clear drops press
    add(0, 0, 0, 1, 0, 11,  31, 0, 0, 0,   31, 0, 0, 0,   0); // held press: no edge
    add(0, 0, 0, 0, 0, 11,  31, 0, 0, 0,   31, 0, 0, 0,   0);
    add(1, 0, 0, 1, 0, 12,  31, 0, 0, 0,   31, 0, 0, 0,   0); // press across reset release
    add(0, 0, 0, 1, 0, 12,  31, 0, 0, 0,   31, 0, 0, 0,   0);
    add(0, 0, 0, 0, 0, 12,  31, 0, 0, 0,   31, 0, 0, 0,   0);
    add(0, 0, 0, 1, 0, 12,  12, 1, 0, 1,   12, 1, 0, 1,   1);
    add(0, 0, 0, 0, 1, 12,  12, 0, 0, 1,   12, 0, 0, 1,   1);
    add(0, 0, 0, 1, 0, 14,  12, 0, 0, 1,   12, 0, 0, 1,   1); // just above range
    add(0, 0, 0, 0, 0, 14,  12, 0, 0, 1,   12, 0, 0, 1,   1);
    add(0, 0, 0, 1, 0, 9,   12, 0, 0, 1,   12, 0, 0, 1,   1); // just below range
    add(0, 0, 0, 0, 0, 9,   12, 0, 0, 1,   12, 0, 0, 1,   1);
    add(0, 0, 0, 1, 0, 13,  13, 1, 0, 2,   13, 1, 0, 2,   2); // upper bound accepted
    add(0, 0, 0, 0, 0, 13,  13, 1, 0, 2,   13, 1, 0, 2,   2);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      v = vecs[i];
      drive(v.rst, v.clr, v.hold, v.press, v.rdy, v.key);
      sb.push_back(v);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk("a_code",  i, 8'(if_a.op_code),  8'(e.a_code));
      chk("a_valid", i, 8'(if_a.op_valid), 8'(e.a_valid));
      chk("a_rej",   i, 8'(if_a.rejected), 8'(e.a_rej));
      chk("a_count", i, 8'(if_a.op_count), 8'(e.a_cnt));
      chk("b_code",  i, 8'(if_b.op_code),  8'(e.b_code));
      chk("b_valid", i, 8'(if_b.op_valid), 8'(e.b_valid));
      chk("b_rej",   i, 8'(if_b.rejected), 8'(e.b_rej));
      chk("b_count", i, 8'(if_b.op_count), 8'(e.b_cnt));
      chk("c_code",  i, 8'(if_c.op_code),  8'(e.a_code));
      chk("c_count", i, 8'(if_c.op_count), 8'(e.c_cnt));
    end

    // Rejection pulse pending when clear arrives: clear must kill it and zero the counters.
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10);
    @(posedge clock); #1;
    chk("seq_a_code", 100, 8'(if_a.op_code),  8'd10);
    chk("seq_a_cnt",  100, 8'(if_a.op_count), 8'd3);
    chk("seq_b_code", 100, 8'(if_b.op_code),  8'd13);
    chk("seq_b_rej",  100, 8'(if_b.rejected), 8'd1);
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10);
    @(posedge clock); #1;
    chk("seq_b_rej",   101, 8'(if_b.rejected), 8'd0);
    chk("seq_b_code",  101, 8'(if_b.op_code),  8'd31);
    chk("seq_b_cnt",   101, 8'(if_b.op_count), 8'd0);
    chk("seq_a_valid", 101, 8'(if_a.op_valid), 8'd0);
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10);
    @(posedge clock); #1;
    chk("seq_b_rej",   102, 8'(if_b.rejected), 8'd0);
    chk("seq_b_valid", 102, 8'(if_b.op_valid), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
